// File: rtl/disp_pkg.sv
// Shared definitions for the score display: colours, mode codes and the
// per-pixel flag word carried alongside the ROM read.
package disp_pkg;

   typedef logic [23:0] rgb_t;

   localparam rgb_t RED   = 24'hFF0000;
   localparam rgb_t BLACK = 24'h000000;
   localparam rgb_t TINT  = 24'h404040;

   typedef enum logic [1:0] {
      MODE_OUTLINE = 2'b00,
      MODE_BLINK   = 2'b01,
      MODE_FILL    = 2'b10,
      MODE_INVERT  = 2'b11
   } mode_e;

   // Overlay flags computed from the pixel coordinates, delayed to meet rom_data
   typedef struct packed {
      logic dis_en;
      logic border;
      logic cell_in;
      logic cell_edge;
      logic blink_vis;
   } flags_t;

   // Ceiling log2, usable in constant expressions
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/score_cursor_display_if.sv
// Bitmap ROM port: the display drives the address, the ROM returns one bit.
interface score_cursor_display_if #(
   parameter int AW = 17
) ();
   logic [AW-1:0] rom_addr;
   logic          rom_data;

   modport master (output rom_addr, input  rom_data);
   modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/disp_delay_line.sv
// N-stage register pipeline of a W-bit word; used to hold the overlay flags
// back until the matching ROM bit arrives.
module disp_delay_line #(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage_q [N];

   // Shift one stage per clock
   // NOTE: each stage is a pipeline flag, not storage, so all stages reset;
   // otherwise stale flags would leak out after a mid-frame reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[N-1];

endmodule

// File: rtl/score_cursor_display.sv
// Centres a 1-bit bitmap on the active display, draws a border around it and
// overlays a (optionally blinking) note cursor on a CELL x CELL grid.
// Coordinates to pixel_data latency is ROM_LAT+1 cycles.
module score_cursor_display
   import disp_pkg::*;
#(
   parameter int H_DISP     = 800,
   parameter int V_DISP     = 600,
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 256,
   parameter int CELL       = 32,
   parameter int BORDER_W   = 2,
   parameter int ROM_LAT    = 1,
   parameter int IDX_OFFSET = 2,
   parameter int BLINK_FR   = 16
) (
   input  logic                          pixel_clk,
   input  logic                          sys_rst_n,
   input  logic [10:0]                   pixel_xpos,
   input  logic [10:0]                   pixel_ypos,
   input  logic [7:0]                    note_idx,
   input  logic                          cur_en,
   input  logic [1:0]                    mode,
   input  logic [23:0]                   fg_color,
   score_cursor_display_if.master        rom,
   output logic [23:0]                   pixel_data
);

   localparam int XW    = clog2(IMG_W);
   localparam int YW    = clog2(IMG_H);
   localparam int CW    = clog2(CELL);
   localparam int COLS  = IMG_W / CELL;
   localparam int COLW  = clog2(COLS);
   localparam int CELLS = COLS * (IMG_H / CELL);
   localparam int FCW   = (BLINK_FR > 1) ? clog2(BLINK_FR) : 1;

   localparam logic [10:0] X0 = 11'((H_DISP - IMG_W) / 2);
   localparam logic [10:0] Y0 = 11'((V_DISP - IMG_H) / 2);

   // Reject parameter sets the 11-bit datapath or the power-of-2 mapping cannot handle
   if (H_DISP > 2047 || V_DISP > 2047 || IMG_W > H_DISP || IMG_H > V_DISP) begin : g_bad_size
      $error("score_cursor_display: image does not fit the 11-bit display");
   end
   if ((IMG_W & (IMG_W - 1)) != 0 || (IMG_H & (IMG_H - 1)) != 0 ||
       (CELL & (CELL - 1)) != 0 || CELL > IMG_W || CELL > IMG_H) begin : g_bad_pow2
      $error("score_cursor_display: IMG_W, IMG_H, CELL must be powers of 2, CELL <= image");
   end
   if (ROM_LAT < 1 || ROM_LAT > 3 || BLINK_FR < 1 || BORDER_W < 0 ||
       2 * BORDER_W > IMG_H || IDX_OFFSET < 0 || IDX_OFFSET > 255) begin : g_bad_misc
      $error("score_cursor_display: ROM_LAT, BLINK_FR, BORDER_W or IDX_OFFSET out of range");
   end

   logic [7:0]    note_q, note_d;
   logic          cur_en_q, cur_en_d;
   logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
   logic          blink_hidden_q, blink_hidden_d;
   logic          frame_seen_q, frame_seen_d;
   logic [XW+YW-1:0] rom_addr_q, rom_addr_d;
   rgb_t          pixel_data_q, pixel_data_d;

   flags_t        flags_d, flags_dly;
   logic [10:0]   rel_x, rel_y, adj, col, row, cx, cy;
   logic          dis_en, cur_valid;
   mode_e         mode_sel;
   logic          img_bit, show_cur;
   rgb_t          img_rgb;

   // State registers: frame-level latches and the two pipeline ends
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         note_q         <= '0;
         cur_en_q       <= 1'b0;
         frame_cnt_q    <= '0;
         blink_hidden_q <= 1'b0;
         frame_seen_q   <= 1'b0;
         rom_addr_q     <= '0;
         pixel_data_q   <= BLACK;
      end else begin
         note_q         <= note_d;
         cur_en_q       <= cur_en_d;
         frame_cnt_q    <= frame_cnt_d;
         blink_hidden_q <= blink_hidden_d;
         frame_seen_q   <= frame_seen_d;
         rom_addr_q     <= rom_addr_d;
         pixel_data_q   <= pixel_data_d;
      end
   end

   // Frame start (0,0): latch cursor index/enable, advance the blink counter
   // NOTE: every output of this block is given a default first so no path
   // leaves a signal unassigned and infers a latch.
   always_comb begin
      note_d         = note_q;
      cur_en_d       = cur_en_q;
      frame_cnt_d    = frame_cnt_q;
      blink_hidden_d = blink_hidden_q;
      frame_seen_d   = frame_seen_q;
      if (pixel_xpos == 11'd0 && pixel_ypos == 11'd0) begin
         note_d       = note_idx;
         cur_en_d     = cur_en;
         frame_seen_d = 1'b1;
         if (frame_cnt_q == FCW'(BLINK_FR - 1)) begin
            frame_cnt_d    = '0;
            blink_hidden_d = ~blink_hidden_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
         end
      end
   end

   // Stage 0: image window, ROM address, border and cursor-cell flags
   always_comb begin
      dis_en = (pixel_xpos >= X0) && (pixel_xpos < X0 + 11'(IMG_W)) &&
               (pixel_ypos >= Y0) && (pixel_ypos < Y0 + 11'(IMG_H));
      rel_x  = pixel_xpos - X0;
      rel_y  = pixel_ypos - Y0;

      adj       = {3'b000, note_q} - 11'(IDX_OFFSET);
      cur_valid = cur_en_q && ({3'b000, note_q} >= 11'(IDX_OFFSET)) && (adj < 11'(CELLS));
      col       = adj & 11'(COLS - 1);
      row       = adj >> COLW;
      cx        = X0 + (col << CW);
      cy        = Y0 + (row << CW);

      rom_addr_d = dis_en ? {rel_y[YW-1:0], rel_x[XW-1:0]} : '0;

      flags_d.dis_en    = dis_en && frame_seen_q;
      flags_d.border    = dis_en &&
                          (rel_x < 11'(BORDER_W) || rel_x >= 11'(IMG_W - BORDER_W) ||
                           rel_y < 11'(BORDER_W) || rel_y >= 11'(IMG_H - BORDER_W));
      flags_d.cell_in   = dis_en && cur_valid &&
                          (pixel_xpos >= cx) && (pixel_xpos < cx + 11'(CELL)) &&
                          (pixel_ypos >= cy) && (pixel_ypos < cy + 11'(CELL));
      flags_d.cell_edge = flags_d.cell_in &&
                          (pixel_xpos == cx || pixel_xpos == cx + 11'(CELL - 1) ||
                           pixel_ypos == cy || pixel_ypos == cy + 11'(CELL - 1));
      flags_d.blink_vis = ~blink_hidden_q;
   end

   // Hold the flags back so they meet the ROM bit for the same pixel
   disp_delay_line #(.W($bits(flags_t)), .N(ROM_LAT)) u_flag_dly (
      .clk   (pixel_clk),
      .rst_n (sys_rst_n),
      .d     (flags_d),
      .q     (flags_dly)
   );

   // Output stage: priority outline > border > image (tinted in fill mode) > black
   always_comb begin
      mode_sel     = mode_e'(mode);
      img_bit      = rom.rom_data ^ (mode_sel == MODE_INVERT);
      img_rgb      = img_bit ? fg_color : BLACK;
      show_cur     = (mode_sel != MODE_BLINK) || flags_dly.blink_vis;
      pixel_data_d = BLACK;
      if (flags_dly.dis_en) begin
         if (flags_dly.cell_edge && show_cur) begin
            pixel_data_d = RED;
         end else if (flags_dly.border) begin
            pixel_data_d = RED;
         end else if (mode_sel == MODE_FILL && flags_dly.cell_in && show_cur) begin
            pixel_data_d = img_rgb | TINT;
         end else begin
            pixel_data_d = img_rgb;
         end
      end
   end

   assign rom.rom_addr = rom_addr_q;
   assign pixel_data   = pixel_data_q;

endmodule
